audio_dac_serializer: RTL and testbench

//  Transmit end of the codec audio path: takes parallel 16-bit stereo samples from the DSP subsystem output and serializes them to the codec DAC in I2S format.

---
 rtl/audio_dac_serializer.sv | 110 +++++++++++
 tb/tb_audio_dac_serializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_serializer.sv
// I2S transmit serializer: parallel stereo samples in, BCLK/LRCK/DACDAT out.
// One-deep holding register decouples the producer; an empty hold at frame start repeats the last pair.
module audio_dac_serializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BCLK_DIV     = 4,
  parameter int SLOT_BITS    = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] left_sample,
  input  logic [SAMPLE_WIDTH-1:0] right_sample,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    bclk,
  output logic                    lrck,
  output logic                    dacdat,
  output logic                    sample_tick,
  output logic                    underrun
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int PW = $clog2(2 * SLOT_BITS);
  localparam int IW = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state, state_nxt;
  logic [DW-1:0]             div_cnt;
  logic [PW-1:0]             p_cnt, p_nxt, slot_pos;
  logic [2*SAMPLE_WIDTH-1:0] hold;
  logic                      hold_full, hold_full_nxt;
  logic [SAMPLE_WIDTH-1:0]   shift_l, shift_r, chan;
  logic [IW-1:0]             bit_idx;
  logic                      tick, accept, frame_start, enter_run;
  logic                      div_wrap, fall_evt, lrck_nxt, dat_nxt;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    enter_run     = 1'b0;
    case (state)
      IDLE: if (hold_full) begin
        state_nxt = RUN;
        enter_run = 1'b1;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase

    frame_start   = (state == RUN) && tick;
    accept        = sample_valid && sample_ready;
    hold_full_nxt = hold_full;
    if (frame_start && hold_full) hold_full_nxt = 1'b0;
    if (accept)                   hold_full_nxt = 1'b1;

    div_wrap = (state == RUN) && (div_cnt == DW'(BCLK_DIV - 1));
    fall_evt = div_wrap && bclk;

    // Everything below describes the frame position that the next falling event enters.
    p_nxt    = (p_cnt == PW'(2 * SLOT_BITS - 1)) ? '0 : p_cnt + 1'b1;
    lrck_nxt = (p_nxt >= PW'(SLOT_BITS));
    slot_pos = lrck_nxt ? p_nxt - PW'(SLOT_BITS) : p_nxt;
    chan     = lrck_nxt ? shift_r : shift_l;
    bit_idx  = IW'(SAMPLE_WIDTH - 1) - IW'(slot_pos - 1'b1);
    dat_nxt  = (slot_pos != '0 && slot_pos <= PW'(SAMPLE_WIDTH)) ? chan[bit_idx] : 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt      <= '0;
      p_cnt        <= '0;
      bclk         <= 1'b0;
      lrck         <= 1'b0;
      dacdat       <= 1'b0;
      tick         <= 1'b0;
      hold         <= '0;
      hold_full    <= 1'b0;
      sample_ready <= 1'b0;
      shift_l      <= '0;
      shift_r      <= '0;
    end else begin
      hold_full    <= hold_full_nxt;
      sample_ready <= !hold_full_nxt;
      tick         <= enter_run || (fall_evt && p_nxt == '0);
      if (accept) hold <= {left_sample, right_sample};
      if (frame_start && hold_full) {shift_l, shift_r} <= hold;
      if (state == RUN) begin
        if (div_wrap) begin
          div_cnt <= '0;
          bclk    <= ~bclk;
          if (bclk) begin
            p_cnt  <= p_nxt;
            lrck   <= lrck_nxt;
            dacdat <= dat_nxt;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  assign sample_tick = tick;
  assign underrun    = frame_start && !hold_full;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer at BCLK_DIV=2, SLOT_BITS=32 (256-clock frames).
// Frames are decoded from dacdat/lrck at each bclk rise and compared with hand-written pairs.
module tb_audio_dac_serializer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] left_sample = '0, right_sample = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, bclk, lrck, dacdat, sample_tick, underrun;

  int n_cmp = 0, n_mis = 0;

  logic        pend = 1'b0;
  logic [15:0] r_l, r_r;
  int          r_pad, r_lr, r_rises, r_mid, r_first, r_nacc, r_acc;
  logic        r_dac4, r_ntick, r_nunder;

  audio_dac_serializer #(.SAMPLE_WIDTH(16), .BCLK_DIV(2), .SLOT_BITS(32)) dut (
    .clock(clock), .reset(reset),
    .left_sample(left_sample), .right_sample(right_sample),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .bclk(bclk), .lrck(lrck), .dacdat(dacdat),
    .sample_tick(sample_tick), .underrun(underrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    pend         = 1'b1;
    sample_valid = 1'b1;
    left_sample  = l;
    right_sample = r;
  endtask

  // One clock; outputs are observed 1 time unit after the edge.
  task automatic step(output logic acc);
    acc = pend && sample_ready;
    @(posedge clock);
    #1;
    if (acc) begin
      pend         = 1'b0;
      sample_valid = 1'b0;
    end
  endtask

  // Call on a frame-start cycle; returns on the next frame-start cycle.
  task automatic run_frame(input int sa, input logic [15:0] la, input logic [15:0] ra,
                           input int sb, input logic [15:0] lb, input logic [15:0] rb);
    logic prev, acc;
    int   k;
    r_l = '0; r_r = '0; r_pad = 0; r_lr = 0; r_rises = 0; r_mid = 0;
    r_first = -1; r_nacc = 0; r_acc = -1; r_dac4 = 1'b0;
    prev = bclk;
    for (int i = 1; i <= 256; i++) begin
      if (i == sa) offer(la, ra);
      if (i == sb) offer(lb, rb);
      step(acc);
      if (acc) begin r_nacc++; r_acc = i; end
      if (i == 4) r_dac4 = dacdat;
      if (i < 256 && sample_tick) r_mid++;
      if (!prev && bclk) begin
        k = r_rises;
        r_rises++;
        if (r_first < 0) r_first = i;
        if (k < 32) begin
          if (k >= 1 && k <= 16) r_l[16-k] = dacdat;
          else if (dacdat) r_pad++;
          if (lrck !== 1'b0) r_lr++;
        end else begin
          if (k - 32 >= 1 && k - 32 <= 16) r_r[48-k] = dacdat;
          else if (dacdat) r_pad++;
          if (lrck !== 1'b1) r_lr++;
        end
      end
      prev = bclk;
    end
    r_ntick  = sample_tick;
    r_nunder = underrun;
  endtask

  task automatic check_frame(input string tag, input logic [15:0] el, input logic [15:0] er,
                             input logic eunder, input int enacc, input int eacc);
    chk({tag, "_left"},      {16'h0, r_l}, {16'h0, el});
    chk({tag, "_right"},     {16'h0, r_r}, {16'h0, er});
    chk({tag, "_pad"},       r_pad, 0);
    chk({tag, "_lrck"},      r_lr, 0);
    chk({tag, "_rises"},     r_rises, 64);
    chk({tag, "_midtick"},   r_mid, 0);
    chk({tag, "_firstrise"}, r_first, 2);
    chk({tag, "_msb_at4"},   {31'h0, r_dac4}, {31'h0, el[15]});
    chk({tag, "_tick256"},   {31'h0, r_ntick}, 32'h1);
    chk({tag, "_underrun"},  {31'h0, r_nunder}, {31'h0, eunder});
    chk({tag, "_naccept"},   r_nacc, enacc);
    if (enacc > 0) chk({tag, "_acc_step"}, r_acc, eacc);
  endtask

  initial begin
    logic acc;
    for (int i = 0; i < 3; i++) step(acc);
    chk("rst_bclk",  {31'h0, bclk}, 32'h0);
    chk("rst_lrck",  {31'h0, lrck}, 32'h0);
    chk("rst_dat",   {31'h0, dacdat}, 32'h0);
    chk("rst_tick",  {31'h0, sample_tick}, 32'h0);
    chk("rst_under", {31'h0, underrun}, 32'h0);
    chk("rst_ready", {31'h0, sample_ready}, 32'h0);

    reset = 1'b0;
    step(acc);
    chk("ready_after_rst", {31'h0, sample_ready}, 32'h1);

    offer(16'hA5F0, 16'h0F0F);
    step(acc);
    chk("t1_accepted", {31'h0, acc}, 32'h1);
    chk("t1_ready_low", {31'h0, sample_ready}, 32'h0);
    chk("t1_tick_early", {31'h0, sample_tick}, 32'h0);
    step(acc);
    chk("t1_entry_tick", {31'h0, sample_tick}, 32'h1);
    chk("t1_entry_under", {31'h0, underrun}, 32'h0);

    run_frame(-1, '0, '0, -1, '0, '0);
    check_frame("f1", 16'hA5F0, 16'h0F0F, 1'b1, 0, 0);

    run_frame(10, 16'h1234, 16'hABCD, 50, 16'h5A5A, 16'hC3C3);
    check_frame("f2", 16'hA5F0, 16'h0F0F, 1'b0, 1, 10);
    chk("f2_end_ready", {31'h0, sample_ready}, 32'h0);

    run_frame(-1, '0, '0, -1, '0, '0);
    check_frame("f3", 16'h1234, 16'hABCD, 1'b0, 1, 2);

    run_frame(-1, '0, '0, -1, '0, '0);
    check_frame("f4", 16'h5A5A, 16'hC3C3, 1'b1, 0, 0);

    run_frame(1, 16'h8001, 16'h7FFE, -1, '0, '0);
    check_frame("f5", 16'h5A5A, 16'hC3C3, 1'b0, 1, 1);

    run_frame(-1, '0, '0, -1, '0, '0);
    check_frame("f6", 16'h8001, 16'h7FFE, 1'b1, 0, 0);

    for (int i = 0; i < 83; i++) step(acc);
    chk("pre_rst_bclk", {31'h0, bclk}, 32'h1);
    reset = 1'b1;
    step(acc);
    chk("mid_rst_bclk",  {31'h0, bclk}, 32'h0);
    chk("mid_rst_lrck",  {31'h0, lrck}, 32'h0);
    chk("mid_rst_dat",   {31'h0, dacdat}, 32'h0);
    chk("mid_rst_tick",  {31'h0, sample_tick}, 32'h0);
    chk("mid_rst_under", {31'h0, underrun}, 32'h0);
    chk("mid_rst_ready", {31'h0, sample_ready}, 32'h0);
    step(acc);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(acc);
    chk("idle_bclk", {31'h0, bclk}, 32'h0);
    chk("idle_tick", {31'h0, sample_tick}, 32'h0);
    chk("idle_ready", {31'h0, sample_ready}, 32'h1);

    offer(16'h8000, 16'h7FFF);
    step(acc);
    chk("t4_accepted", {31'h0, acc}, 32'h1);
    step(acc);
    chk("t4_entry_tick", {31'h0, sample_tick}, 32'h1);

    run_frame(10, 16'h8000, 16'hFFFF, -1, '0, '0);
    check_frame("f7", 16'h8000, 16'h7FFF, 1'b0, 1, 10);
    for (int f = 0; f < 3; f++) begin
      run_frame(10, 16'h8000, 16'hFFFF, -1, '0, '0);
      check_frame($sformatf("sweep%0d", f), 16'h8000, 16'hFFFF, 1'b0, 1, 10);
    end
    run_frame(-1, '0, '0, -1, '0, '0);
    check_frame("sweep3", 16'h8000, 16'hFFFF, 1'b1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
